// File: rtl/tlb_refill_alloc.sv
// tlb_refill_alloc: TLB/cache refill entry allocator. It picks the lowest free entry, or a victim when all entries are valid.
//   Ports: clk, resetn (async active-low)
//          alloc_req -> alloc_valid / alloc_idx / alloc_victim, alloc_ack (grant handshake)
//          inv_en / inv_mask (valid clearing), vld / full / empty (valid state)
//   Optional build macro ALLOC_LFSR_EN: victim taken from a 16-bit LFSR instead of a round-robin pointer.
module tlb_refill_alloc #(
  parameter int N    = 16,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            alloc_req,
  output logic            alloc_valid,
  output logic [IDXW-1:0] alloc_idx,
  output logic            alloc_victim,
  input  logic            alloc_ack,
  input  logic            inv_en,
  input  logic [N-1:0]    inv_mask,
  output logic [N-1:0]    vld,
  output logic            full,
  output logic            empty
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t          state_q, state_d;
  logic [N-1:0]    vld_q, vld_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            victim_q, victim_d;
  logic [IDXW-1:0] free_idx, victim_idx;
  logic            grant, done, all_vld;
  assign all_vld = &vld_q;
  assign grant   = (state_q == IDLE) && alloc_req;
  assign done    = (state_q == HOLD) && alloc_ack;
  // Scanning from the top down leaves the lowest clear bit as the final assignment.
  always_comb begin
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (!vld_q[i]) free_idx = IDXW'(i);
  end
`ifdef ALLOC_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign victim_idx = lfsr_q[IDXW-1:0];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
`else
  logic [IDXW-1:0] rr_q, rr_d;
  // The pointer moves only when a replacement grant is consumed. N is a power of two, so it wraps on its own.
  assign rr_d       = (done && victim_q) ? rr_q + 1'b1 : rr_q;
  assign victim_idx = rr_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) rr_q <= '0;
    else         rr_q <= rr_d;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q  <= IDLE;
      vld_q    <= '0;
      idx_q    <= '0;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      idx_q    <= idx_d;
      victim_q <= victim_d;
    end
  always_comb
    state_d = (state_q == IDLE) ? (alloc_req ? HOLD : IDLE) : (alloc_ack ? IDLE : HOLD);
  // The ack set is ORed in after the invalidate clear, so the set wins when both hit the same bit.
  always_comb begin
    idx_d    = grant ? (all_vld ? victim_idx : free_idx) : idx_q;
    victim_d = grant ? all_vld : victim_q;
    vld_d    = (vld_q & ~(inv_en ? inv_mask : '0)) | (done ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0);
  end
  always_comb begin
    alloc_valid  = (state_q == HOLD);
    alloc_idx    = idx_q;
    alloc_victim = victim_q;
    vld          = vld_q;
    full         = all_vld;
    empty        = ~|vld_q;
  end
endmodule

// File: tb/tb_tlb_refill_alloc.sv
// tb_tlb_refill_alloc: directed self-checking bench for tlb_refill_alloc with N=16.
module tb_tlb_refill_alloc;
  logic        clk = 1'b0;
  logic        resetn, alloc_req, alloc_ack, inv_en;
  logic [15:0] inv_mask;
  logic        alloc_valid, alloc_victim, full, empty;
  logic [3:0]  alloc_idx;
  logic [15:0] vld;
  logic [15:0] lfsr_m;
  int n_cmp = 0;
  int n_err = 0;
  logic [3:0]  g_idx;
  logic        g_vic;
  logic [15:0] g_lfsr;

  tlb_refill_alloc #(.N(16), .IDXW(4)) dut (
    .clk(clk), .resetn(resetn), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_idx(alloc_idx), .alloc_victim(alloc_victim), .alloc_ack(alloc_ack),
    .inv_en(inv_en), .inv_mask(inv_mask), .vld(vld), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seeded 16'hACE1 and stepped on every edge.
  always @(posedge clk or negedge resetn)
    if (!resetn) lfsr_m <= 16'hACE1;
    else         lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One grant takes two cycles: a request cycle, then a hold cycle that acks.
  task automatic req_ack(output logic [3:0] idx, output logic vic, output logic [15:0] lp);
    @(negedge clk);
    alloc_req = 1'b1;
    lp = lfsr_m;
    @(negedge clk);
    alloc_req = 1'b0;
    check("grant_valid", alloc_valid, 1);
    idx = alloc_idx;
    vic = alloc_victim;
    alloc_ack = 1'b1;
    @(negedge clk);
    alloc_ack = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; alloc_req = 1'b0; alloc_ack = 1'b0; inv_en = 1'b0; inv_mask = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", alloc_valid, 0);
    check("rst_idx", alloc_idx, 0);
    check("rst_victim", alloc_victim, 0);
    check("rst_vld", vld, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_ack(g_idx, g_vic, g_lfsr);
      check("first_idx", g_idx, k);
      check("first_victim", g_vic, 0);
    end
    check("first_vld", vld, 16'h0007);
    check("first_empty", empty, 0);
    check("first_valid_idle", alloc_valid, 0);
    @(negedge clk);
    inv_en = 1'b1; inv_mask = 16'h0002;
    @(negedge clk);
    inv_en = 1'b0; inv_mask = '0;
    check("inv_vld", vld, 16'h0005);
    req_ack(g_idx, g_vic, g_lfsr);
    check("hole_idx", g_idx, 1);
    check("hole_vld", vld, 16'h0007);
    for (int k = 3; k < 16; k++) begin
      check("build_full", full, 0);
      req_ack(g_idx, g_vic, g_lfsr);
      check("build_idx", g_idx, k);
    end
    check("full_flag", full, 1);
    check("full_vld", vld, 16'hFFFF);
    for (int k = 0; k < 17; k++) begin
      req_ack(g_idx, g_vic, g_lfsr);
`ifdef ALLOC_LFSR_EN
      check("lfsr_victim_idx", g_idx, g_lfsr[3:0]);
`else
      check("rr_victim_idx", g_idx, k % 16);
`endif
      check("victim_flag", g_vic, 1);
      check("victim_vld", vld, 16'hFFFF);
    end
    @(negedge clk);
    inv_en = 1'b1; inv_mask = 16'hFFFF;
    @(negedge clk);
    inv_en = 1'b0; inv_mask = '0;
    check("clear_empty", empty, 1);
    alloc_req = 1'b1;
    @(negedge clk);
    check("busy_valid0", alloc_valid, 1);
    check("busy_idx0", alloc_idx, 0);
    @(negedge clk);
    check("busy_valid1", alloc_valid, 1);
    check("busy_idx1", alloc_idx, 0);
    alloc_ack = 1'b1;
    @(negedge clk);
    alloc_ack = 1'b0; alloc_req = 1'b0;
    check("busy_after_ack", alloc_valid, 0);
    check("busy_vld", vld, 16'h0001);
    for (int k = 1; k < 5; k++) begin
      req_ack(g_idx, g_vic, g_lfsr);
      check("pre_coll_idx", g_idx, k);
    end
    @(negedge clk);
    alloc_req = 1'b1;
    @(negedge clk);
    alloc_req = 1'b0;
    check("coll_idx", alloc_idx, 5);
    alloc_ack = 1'b1; inv_en = 1'b1; inv_mask = 16'h0020;
    @(negedge clk);
    alloc_ack = 1'b0; inv_en = 1'b0; inv_mask = '0;
    check("coll_vld", vld, 16'h003F);
    @(negedge clk);
    alloc_req = 1'b1;
    @(negedge clk);
    alloc_req = 1'b0;
    check("pre_rst_valid", alloc_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_valid", alloc_valid, 0);
    check("async_rst_vld", vld, 0);
    check("async_rst_idx", alloc_idx, 0);
    #1 resetn = 1'b1;
    req_ack(g_idx, g_vic, g_lfsr);
    check("post_rst_idx", g_idx, 0);
    check("post_rst_victim", g_vic, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/tlb_refill_alloc.md
# tlb_refill_alloc

Entry allocator feeding a TLB/cache fill port: keeps a per-entry valid vector, picks the lowest-numbered free entry on request (priority one-hot select, then encode to an index) and, when every entry is valid, supplies a replacement victim instead. It sits directly upstream of the entry write path. It owns the TLBFILL/refill index decision and the INVTLB-style valid clearing.

## Interface
- `N`, 16: number of entries; power of two, 4..64.
- `IDXW`, 4: index width; must equal log2(N).
- `clk` input 1: clock, rising edge.
- `resetn` input 1: asynchronous active-low reset.
- `alloc_req` input 1: request an entry index; sampled only in IDLE.
- `alloc_valid` output 1: `alloc_idx` is valid and held.
- `alloc_idx` output IDXW: granted entry index.
- `alloc_victim` output 1: grant is a replacement (all entries were valid at pick time).
- `alloc_ack` input 1: consumer wrote the entry; meaningful only while `alloc_valid`.
- `inv_en` input 1: clear valid bits selected by `inv_mask`.
- `inv_mask` input N: per-entry clear mask.
- `vld` output N: current valid vector.
- `full` output 1: all valid bits set.
- `empty` output 1: no valid bits set.

## Operation
- State machine, two states:
  - IDLE: `alloc_valid`=0.
  - HOLD: `alloc_valid`=1.
- IDLE with `alloc_req`=1 → HOLD next edge.
  - Pick from `vld` as seen in that cycle (before that edge's updates).
  - Not full: `alloc_idx` = index of lowest clear bit; `alloc_victim`=0.
  - Full: `alloc_idx` = victim per Configuration; `alloc_victim`=1.
- HOLD: `alloc_idx` and `alloc_victim` stay stable; `alloc_req` ignored.
- HOLD with `alloc_ack`=1 → IDLE next edge; `vld[alloc_idx]` set at that edge.
- `alloc_ack` in IDLE is ignored.
- `inv_en`=1: `vld &= ~inv_mask` at next edge, in any state.
- Ack and invalidate on the same edge for the same bit: set wins (bit ends 1).
- Invalidate clearing the held `alloc_idx` during HOLD: grant is unchanged; the later ack sets the bit again.
- `full` = AND of `vld`; `empty` = NOR of `vld`; both combinational from the register.

## Timing
- Reset values:
  - state IDLE; `vld`=0; `alloc_valid`=0; `alloc_idx`=0; `alloc_victim`=0.
  - `full`=0; `empty`=1; round-robin pointer 0; LFSR 16'hACE1.
- Reset is asynchronous: asserting `resetn` mid-HOLD drops `alloc_valid` immediately; any pending grant is lost.
- Latency: `alloc_req` in cycle t → `alloc_valid`=1 in t+1.
- Grant hold: minimum 1 cycle (ack at t+1 → IDLE at t+2).
- Back-to-back throughput: one grant per 2 cycles. A request in the IDLE cycle after an ack sees the updated `vld`.
- `alloc_idx`, `alloc_victim` and `alloc_valid` are registered outputs; no combinational path from inputs.

## Configuration
- `ALLOC_LFSR_EN` defined:
  - Victim = LFSR[IDXW-1:0].
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle including in HOLD.
  - Round-robin pointer is absent.
- `ALLOC_LFSR_EN` undefined:
  - Victim = round-robin pointer.
  - Pointer increments mod N on each acked victim grant.
  - Pointer does not change on non-victim grants, wrapping N-1 → 0.
  - LFSR is absent.

## Test plan
- Three req/ack pairs after reset → `alloc_idx` 0,1,2, `alloc_victim`=0; `vld`=0x0007 with N=16; `empty` 1→0.
- `vld`=0x0007, `inv_en` with `inv_mask`=0x0002, then req → `alloc_idx`=1; after ack `vld`=0x0007.
- Round-robin build, 16 grants to `full`=1, then 17 req/ack pairs:
  - `alloc_idx` 0,1,…,15,0 with `alloc_victim`=1.
  - `vld` stays 0xFFFF.
- Requests while busy and ack/invalidate collision:
  - `alloc_req` held high through HOLD: no second grant until after ack; `alloc_idx` stable throughout HOLD.
  - Same-edge `alloc_ack` (idx 5) and `inv_mask`=0x0020: `vld[5]`=1 afterwards.
- `resetn` pulsed low mid-HOLD: `alloc_valid`=0 and `vld`=0 before the next clock edge; next req → `alloc_idx`=0.
- LFSR build, all full: victim sequence on req/ack pairs spaced 2 cycles matches the reference LFSR model seeded 16'hACE1.
